// File: rtl/iitb_pkg.sv
// Shared definitions for the IITB 16-bit pipelined CPU front end.
//   WORD_W / ADDR_W   : instruction word and byte-address widths
//   fetch_entry_t     : one fetched word plus the address it came from,
//                       packed as {pc[15:0], instr[15:0]}
//   NOP_INSTR         : bubble word inserted by downstream stages
//   pc_advance()      : sequential PC step, wraps modulo 2^ADDR_W
package iitb_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  localparam int FE_W         = ADDR_W + WORD_W;
  localparam int FE_INSTR_LSB = 0;
  localparam int FE_PC_LSB    = WORD_W;

  localparam logic [WORD_W-1:0] NOP_INSTR = 16'hB000;

  // Plain unsigned add; the carry out of bit 15 is dropped on purpose so
  // fetch rolls over from 16'hFFFE to 16'h0000 without any flag.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc,
                                                   input logic [ADDR_W-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/iitb_fetch_fifo.sv
// Circular-buffer queue holding fetched entries between the PC and IF/ID.
//   clk_i, rst_ni : clock, asynchronous active-low reset (control state only)
//   clear_i       : drop every entry on the next edge (wins over push/pop)
//   push_i        : write wdata_i at the tail (ignored when full without pop)
//   pop_i         : retire the head entry (ignored when empty)
//   wdata_i       : entry to write
//   head_o        : head entry, all-zero while empty
//   valid_o       : queue holds at least one entry
//   full_o        : queue holds DEPTH entries
//   count_o       : number of entries held
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module iitb_fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_pop;
  logic do_push;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;

  // A pop frees the slot in the same cycle, so a full queue may still take
  // a push when the head is leaving; the count then stays put.
  assign do_pop  = pop_i & valid_o & ~clear_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push) wr_d = wr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; head_o is masked to zero whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/iitb_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, addresses the combinational
// instruction memory and queues fetched words for the IF/ID register.
//   Clk          : rising-edge clock
//   Reset        : asynchronous active-low reset
//   fetch_en     : 1 = fetch allowed, 0 = hold PC and stop pushing
//   imem_addr    : current fetch PC (registered)
//   imem_data    : instruction word for imem_addr, same cycle
//   stall_in     : IF/ID cannot take the head this cycle
//   flush_in     : redirect to redirect_pc, discard all queued words
//   redirect_pc  : new fetch PC from branch/jump resolution
//   ifid_valid   : head entry valid
//   ifid_instr   : head instruction word (zero when empty)
//   ifid_pc      : address of the head word (zero when empty)
//   q_count      : queue occupancy
module iitb_fetch_stage
  import iitb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 16'd2,
  parameter int                DEPTH    = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   fetch_en,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [WORD_W-1:0]      imem_data,
  input  logic                   stall_in,
  input  logic                   flush_in,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   ifid_valid,
  output logic [WORD_W-1:0]      ifid_instr,
  output logic [ADDR_W-1:0]      ifid_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push;
  logic              pop;
  logic              q_full;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head_entry;

  // The memory address is the registered PC only, so a late flush_in never
  // reaches the instruction memory in the same cycle.
  assign imem_addr = pc_q;

  // Flush outranks everything: the head is not consumed and nothing new is
  // queued on the redirect edge; fetch restarts from redirect_pc next cycle.
  assign pop  = ifid_valid & ~stall_in & ~flush_in;
  assign push = fetch_en & ~flush_in & (~q_full | pop);

  assign wr_entry = '{pc: pc_q, instr: imem_data};

  always_comb begin
    pc_d = pc_q;
    if (flush_in)  pc_d = redirect_pc;
    else if (push) pc_d = pc_advance(pc_q, PC_INC);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  iitb_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FE_W)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .clear_i (flush_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .head_o  (head_entry),
    .valid_o (ifid_valid),
    .full_o  (q_full),
    .count_o (q_count)
  );

  assign ifid_instr = head_entry.instr;
  assign ifid_pc    = head_entry.pc;

endmodule

// File: tb/tb_iitb_fetch_stage.sv
module tb_iitb_fetch_stage;

  localparam int DEPTH = 2;

  logic        Clk;
  logic        Reset;
  logic        fetch_en, stall_in, flush_in;
  logic [15:0] redirect_pc;

  logic [15:0] imem_addr_a, imem_data_a, ifid_instr_a, ifid_pc_a;
  logic        ifid_valid_a;
  logic [1:0]  q_count_a;

  logic [15:0] imem_addr_w, imem_data_w, ifid_instr_w, ifid_pc_w;
  logic        ifid_valid_w;
  logic [1:0]  q_count_w;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  assign imem_data_a = instr_of(imem_addr_a);
  assign imem_data_w = instr_of(imem_addr_w);

  iitb_fetch_stage #(.RESET_PC(16'h0000), .PC_INC(16'd2), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .stall_in(stall_in), .flush_in(flush_in), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid_a), .ifid_instr(ifid_instr_a), .ifid_pc(ifid_pc_a),
    .q_count(q_count_a)
  );

  // Free-running instance used only to observe PC wrap-around.
  iitb_fetch_stage #(.RESET_PC(16'hFFFC), .PC_INC(16'd2), .DEPTH(DEPTH)) dut_w (
    .Clk(Clk), .Reset(Reset), .fetch_en(1'b1),
    .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .stall_in(1'b0), .flush_in(1'b0), .redirect_pc(16'h0000),
    .ifid_valid(ifid_valid_w), .ifid_instr(ifid_instr_w), .ifid_pc(ifid_pc_w),
    .q_count(q_count_w)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetch addresses and a fetch PC.
  logic [15:0] mq[$];
  logic [15:0] mpc;

  task automatic model_reset();
    mq.delete();
    mpc = 16'h0000;
  endtask

  task automatic model_edge(input logic fe, input logic st, input logic fl, input logic [15:0] rp);
    bit v, pp, ps;
    v  = (mq.size() > 0);
    pp = v && !st && !fl;
    ps = fe && !fl && ((mq.size() < DEPTH) || pp);
    if (fl) begin
      mq.delete();
      mpc = rp;
    end else begin
      if (pp) void'(mq.pop_front());
      if (ps) begin
        mq.push_back(mpc);
        mpc = mpc + 16'd2;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] epc, ein;
    epc = (mq.size() > 0) ? mq[0] : 16'h0000;
    ein = (mq.size() > 0) ? instr_of(mq[0]) : 16'h0000;
    chk({tag, ".valid"}, {15'd0, ifid_valid_a}, (mq.size() > 0) ? 16'd1 : 16'd0);
    chk({tag, ".pc"},    ifid_pc_a, epc);
    chk({tag, ".instr"}, ifid_instr_a, ein);
    chk({tag, ".count"}, {14'd0, q_count_a}, 16'(mq.size()));
    chk({tag, ".addr"},  imem_addr_a, mpc);
  endtask

  // Apply inputs for one cycle (called just after a falling edge), advance the
  // model on the rising edge, return at the next falling edge for sampling.
  task automatic step(input logic fe, input logic st, input logic fl, input logic [15:0] rp);
    fetch_en    = fe;
    stall_in    = st;
    flush_in    = fl;
    redirect_pc = rp;
    @(posedge Clk);
    model_edge(fe, st, fl, rp);
    @(negedge Clk);
  endtask

  typedef struct {
    logic        fe, st, fl;
    logic [15:0] rp;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] ecnt;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tq[$];

  task automatic add(input logic fe, input logic st, input logic fl, input logic [15:0] rp,
                     input logic ev, input logic [15:0] epc, input logic [15:0] ecnt,
                     input logic [15:0] eaddr);
    vec_t v;
    v.fe = fe; v.st = st; v.fl = fl; v.rp = rp;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    tq.push_back(v);
  endtask

  initial begin
    Reset = 1'b0; fetch_en = 1'b0; stall_in = 1'b0; flush_in = 1'b0; redirect_pc = 16'h0000;
    model_reset();

    //           fe st fl rp        ev  pc       cnt addr
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002);  // first word right after release
    add(1, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0004);
    add(1, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0006);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 2, 16'h0008);  // stall: queue fills
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 2, 16'h0008);  // full: pc holds at X+4
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 2, 16'h0008);
    add(1, 1, 0, 16'h0000, 1, 16'h0004, 2, 16'h0008);
    add(1, 0, 0, 16'h0000, 1, 16'h0006, 2, 16'h000A);  // release: contiguous
    add(1, 0, 0, 16'h0000, 1, 16'h0008, 2, 16'h000C);
    add(1, 1, 0, 16'h0000, 1, 16'h0008, 2, 16'h000C);
    add(1, 1, 1, 16'h0100, 0, 16'h0000, 0, 16'h0100);  // flush on full+stall
    add(1, 0, 0, 16'h0000, 1, 16'h0100, 1, 16'h0102);
    add(1, 0, 0, 16'h0000, 1, 16'h0102, 1, 16'h0104);
    add(1, 0, 1, 16'h0200, 0, 16'h0000, 0, 16'h0200);  // flush with poppable head
    add(1, 0, 0, 16'h0000, 1, 16'h0200, 1, 16'h0202);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0202);  // fetch_en=0 drains
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0202);
    add(1, 0, 0, 16'h0000, 1, 16'h0202, 1, 16'h0204);
    add(1, 1, 0, 16'h0000, 1, 16'h0202, 2, 16'h0206);
    add(0, 0, 0, 16'h0000, 1, 16'h0204, 1, 16'h0206);
    add(1, 0, 0, 16'h0000, 1, 16'h0206, 1, 16'h0208);
    add(1, 0, 1, 16'hFFFE, 0, 16'h0000, 0, 16'hFFFE);
    add(1, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 16'h0000);  // wrap on redirect path
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002);

    // Reset held for three cycles.
    repeat (3) @(negedge Clk);
    chk("rst.valid", {15'd0, ifid_valid_a}, 16'd0);
    chk("rst.instr", ifid_instr_a, 16'h0000);
    chk("rst.pc",    ifid_pc_a, 16'h0000);
    chk("rst.count", {14'd0, q_count_a}, 16'd0);
    chk("rst.addr",  imem_addr_a, 16'h0000);
    chk("rst.addr_w", imem_addr_w, 16'hFFFC);
    Reset = 1'b1;

    foreach (tq[i]) begin
      step(tq[i].fe, tq[i].st, tq[i].fl, tq[i].rp);
      chk($sformatf("vec%0d.valid", i), {15'd0, ifid_valid_a}, {15'd0, tq[i].ev});
      chk($sformatf("vec%0d.pc", i), ifid_pc_a, tq[i].epc);
      chk($sformatf("vec%0d.instr", i), ifid_instr_a,
          tq[i].ev ? instr_of(tq[i].epc) : 16'h0000);
      chk($sformatf("vec%0d.count", i), {14'd0, q_count_a}, tq[i].ecnt);
      chk($sformatf("vec%0d.addr", i), imem_addr_w == imem_addr_w ? imem_addr_a : 16'h0, tq[i].eaddr);
      check_model($sformatf("vec%0d.model", i));
      if (i < 4) begin
        logic [15:0] wexp;
        wexp = 16'hFFFC + 16'(2 * i);
        chk($sformatf("wrap%0d.pc", i), ifid_pc_w, wexp);
        chk($sformatf("wrap%0d.valid", i), {15'd0, ifid_valid_w}, 16'd1);
      end
    end

    // Randomised traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic fe, st, fl;
      logic [15:0] rp;
      fe = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 19) == 0);
      rp = 16'($urandom) & 16'hFFFE;
      step(fe, st, fl, rp);
      check_model($sformatf("rnd%0d", k));
    end

    // Asynchronous reset asserted between clock edges.
    step(1, 1, 0, 16'h0000);
    step(1, 1, 0, 16'h0000);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    chk("arst.valid", {15'd0, ifid_valid_a}, 16'd0);
    chk("arst.instr", ifid_instr_a, 16'h0000);
    chk("arst.pc",    ifid_pc_a, 16'h0000);
    chk("arst.count", {14'd0, q_count_a}, 16'd0);
    chk("arst.addr",  imem_addr_a, 16'h0000);
    chk("arst.addr_w", imem_addr_w, 16'hFFFC);
    @(negedge Clk);
    fetch_en = 1'b1;
    @(negedge Clk);
    chk("arst.hold_addr", imem_addr_a, 16'h0000);
    chk("arst.hold_valid", {15'd0, ifid_valid_a}, 16'd0);
    Reset = 1'b1;

    // fetch_en toggling 1-0-1: pc holds while low, stream has no gaps.
    step(1, 0, 0, 16'h0000);
    chk("tog.pc0", ifid_pc_a, 16'h0000);
    step(1, 1, 0, 16'h0000);
    chk("tog.cnt_full", {14'd0, q_count_a}, 16'd2);
    step(0, 0, 0, 16'h0000);
    chk("tog.hold_addr", imem_addr_a, 16'h0004);
    chk("tog.pc1", ifid_pc_a, 16'h0002);
    check_model("tog.a");
    step(0, 0, 0, 16'h0000);
    check_model("tog.b");
    step(1, 0, 0, 16'h0000);
    chk("tog.pc2", ifid_pc_a, 16'h0004);
    check_model("tog.c");
    step(1, 0, 0, 16'h0000);
    chk("tog.pc3", ifid_pc_a, 16'h0006);
    check_model("tog.d");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
